// File: rtl/aes_pkg.sv
// Shared AES constants and helpers: block/word widths, round constants,
// forward S-box, GF(2^8) doubling. Used by the key schedule and the round
// datapath (mixColumns shares xtime).
package aes_pkg;

  localparam int unsigned AES_STATE_W   = 128;
  localparam int unsigned AES_WORD_W    = 32;
  localparam int unsigned AES128_ROUNDS = 10;

  // 128-bit block viewed as four words; w0 occupies the top bits (byte 0 at [127:120]).
  typedef struct packed {
    logic [AES_WORD_W-1:0] w0;
    logic [AES_WORD_W-1:0] w1;
    logic [AES_WORD_W-1:0] w2;
    logic [AES_WORD_W-1:0] w3;
  } aes_block_t;

  localparam logic [0:9][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/round_key_stream_pkg.sv
// Key-schedule local types: FSM state encoding and round index width.
package round_key_stream_pkg;

  localparam int unsigned RK_ROUND_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } rks_state_t;

endpackage

// File: rtl/round_key_stream_if.sv
// Round-key stream bundle.
//   start/key    : load request and cipher key (consumer -> schedule)
//   rk_valid/rk_ready, rk, rk_round : round-key handshake and payload
//   busy/done    : schedule status
// master = key schedule, slave = consumer/controller.
interface round_key_stream_if;
  import aes_pkg::*;
  import round_key_stream_pkg::*;

  logic                   start;
  logic [AES_STATE_W-1:0] key;
  logic                   rk_valid;
  logic                   rk_ready;
  logic [AES_STATE_W-1:0] rk;
  logic [RK_ROUND_W-1:0]  rk_round;
  logic                   busy;
  logic                   done;

  modport master (
    input  start, key, rk_ready,
    output rk_valid, rk, rk_round, busy, done
  );

  modport slave (
    output start, key, rk_ready,
    input  rk_valid, rk, rk_round, busy, done
  );

endinterface

// File: rtl/aes_sub_word.sv
// SubWord: forward S-box applied to each byte of a 32-bit word (combinational).
//   word  : input word
//   sub_c : substituted word
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [AES_WORD_W-1:0] word,
  output logic [AES_WORD_W-1:0] sub_c
);

  assign sub_c = {SBOX[word[31:24]], SBOX[word[23:16]],
                  SBOX[word[15:8]],  SBOX[word[7:0]]};

endmodule

// File: rtl/round_key_stream.sv
// Iterative AES-128 key schedule: emits round keys 0..ROUNDS over a
// valid/ready handshake, one expansion step per accepted key.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : round_key_stream_if.master (start/key in, rk stream out,
//                busy/done status)
// Build option ROUND_KEY_STREAM_ZEROIZE_EN: clear rk on the final handshake
// so no key material remains after done.
module round_key_stream
  import aes_pkg::*;
  import round_key_stream_pkg::*;
#(
  parameter int unsigned ROUNDS = AES128_ROUNDS
)
(
  input  logic                clk,
  input  logic                rst_n,
  round_key_stream_if.master  bus
);

  rks_state_t            state_q, state_d;
  aes_block_t            rk_q, rk_d, rk_next;
  logic [RK_ROUND_W-1:0] round_q, round_d;
  logic [7:0]            rcon_q, rcon_d;
  logic                  done_q, done_d;

  logic [AES_WORD_W-1:0] sub_c;
  logic [AES_WORD_W-1:0] temp;
  logic                  last_c;

  // SubWord(RotWord(w3)); RotWord is a one-byte left rotate.
  aes_sub_word u_sub_word (
    .word  ({rk_q.w3[23:0], rk_q.w3[31:24]}),
    .sub_c (sub_c)
  );

  // Next round key from the current one.
  assign temp       = sub_c ^ {rcon_q, 24'h0};
  assign rk_next.w0 = rk_q.w0 ^ temp;
  assign rk_next.w1 = rk_q.w1 ^ rk_next.w0;
  assign rk_next.w2 = rk_q.w2 ^ rk_next.w1;
  assign rk_next.w3 = rk_q.w3 ^ rk_next.w2;

  assign last_c = (round_q == RK_ROUND_W'(ROUNDS));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rk_q    <= '0;
      round_q <= '0;
      rcon_q  <= RCON[0];
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          rk_d    = bus.key;
          round_d = '0;
          rcon_d  = RCON[0];
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (bus.rk_ready) begin
          if (last_c) begin
            state_d = IDLE;
            done_d  = 1'b1;
`ifdef ROUND_KEY_STREAM_ZEROIZE_EN
            rk_d    = '0;
`endif
          end else begin
            rk_d    = rk_next;
            round_d = round_q + RK_ROUND_W'(1);
            rcon_d  = xtime(rcon_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rk_valid = (state_q == EMIT);
  assign bus.busy     = (state_q != IDLE);
  assign bus.rk       = rk_q;
  assign bus.rk_round = round_q;
  assign bus.done     = done_q;

endmodule
